// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte producers, each with its own FIFO.
// Round-robin per byte by default; define UART_ARB_LINELOCK_EN to hold the grant until a port sends LF.
module uart_tx_arbiter #(
  parameter int DEPTH        = 4,
  parameter int LOCK_TIMEOUT = 2500
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] req0Data,
  input  logic       req0Stb,
  output logic       req0Rdy,
  input  logic [7:0] req1Data,
  input  logic       req1Stb,
  output logic       req1Rdy,
  output logic [7:0] txData,
  output logic       txStb,
  input  logic       txRdy,
  output logic       grant,
  output logic [1:0] ovf,
  output logic [1:0] dbg_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || LOCK_TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: DEPTH must be a power of two in 2..16 and LOCK_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_HOLD   = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  state_e        state_q;
  logic [7:0]    tx_data_q;
  logic          tx_stb_q;
  logic          grant_q;
  logic          last_grant_q;
  logic [1:0]    ovf_q;
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] rptr_q [2];
  logic [7:0]    mem_q  [2][DEPTH];

  logic [1:0] push_stb;
  logic [7:0] push_data [2];
  logic [1:0] full;
  logic [1:0] empty;
  logic [1:0] push_ok;
  logic [1:0] elig;
  logic [1:0] pop;
  logic       sel;
  logic       do_pop;
  logic [7:0] pop_data;

  assign push_stb     = {req1Stb, req0Stb};
  assign push_data[0] = req0Data;
  assign push_data[1] = req1Data;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      empty[p] = (wptr_q[p] == rptr_q[p]);
      full[p]  = (wptr_q[p][AW-1:0] == rptr_q[p][AW-1:0]) && (wptr_q[p][AW] != rptr_q[p][AW]);
    end
  end

  // A push is judged on pre-edge fullness; a pop in the same cycle does not rescue it.
  assign push_ok = push_stb & ~full;
  assign req0Rdy = ~full[0];
  assign req1Rdy = ~full[1];

`ifdef UART_ARB_LINELOCK_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  logic          lock_q;
  logic          lock_port_q;
  logic [TW-1:0] tmo_q;

  assign elig = ~empty & (lock_q ? (lock_port_q ? 2'b10 : 2'b01) : 2'b11);

  // Timeout only runs while the locked port is starving a waiting neighbour.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_q      <= 1'b0;
      lock_port_q <= 1'b0;
      tmo_q       <= '0;
    end else if (do_pop) begin
      lock_q      <= (pop_data != 8'h0A);
      lock_port_q <= sel;
      tmo_q       <= '0;
    end else if (lock_q) begin
      if (push_stb[lock_port_q] || !empty[lock_port_q] || empty[!lock_port_q]) begin
        tmo_q <= '0;
      end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
        lock_q <= 1'b0;
        tmo_q  <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end
`else
  assign elig = ~empty;
`endif

  always_comb begin
    sel      = elig[1] & (~elig[0] | ~last_grant_q);
    do_pop   = (state_q == S_IDLE) && txRdy && (|elig);
    pop      = 2'b00;
    if (do_pop) pop[sel] = 1'b1;
    pop_data = mem_q[sel][rptr_q[sel][AW-1:0]];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int p = 0; p < 2; p++) begin
        wptr_q[p] <= '0;
        rptr_q[p] <= '0;
      end
      ovf_q <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push_ok[p]) wptr_q[p] <= wptr_q[p] + PW'(1);
        if (pop[p]) rptr_q[p] <= rptr_q[p] + PW'(1);
        if (push_stb[p] && full[p]) ovf_q[p] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      if (push_ok[p]) mem_q[p][wptr_q[p][AW-1:0]] <= push_data[p];
    end
  end

  // HOLD exists because the UART drops txRdy one cycle after the strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      tx_data_q    <= 8'h00;
      tx_stb_q     <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (do_pop) begin
            state_q      <= S_STROBE;
            tx_stb_q     <= 1'b1;
            tx_data_q    <= pop_data;
            grant_q      <= sel;
            last_grant_q <= sel;
          end
        end
        S_STROBE: begin
          tx_stb_q <= 1'b0;
          state_q  <= S_HOLD;
        end
        S_HOLD: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (txRdy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign txData      = tx_data_q;
  assign txStb       = tx_stb_q;
  assign grant       = grant_q;
  assign ovf         = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and random checks of uart_tx_arbiter against a queue-based model of the two FIFOs,
// with a simple UART that drops txRdy the cycle after each strobe.
module tb_uart_tx_arbiter;

  localparam int DEPTH        = 4;
  localparam int LOCK_TIMEOUT = 20;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] req0Data;
  logic       req0Stb;
  logic       req0Rdy;
  logic [7:0] req1Data;
  logic       req1Stb;
  logic       req1Rdy;
  logic [7:0] txData;
  logic       txStb;
  logic       txRdy;
  logic       grant;
  logic [1:0] ovf;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] got_q[$];
  int         stb_cyc_q[$];
  logic [1:0] m_ovf;
  bit         m_last_grant;
  int         cyc;
  int         last_stb_cyc;
  bit         prev_stb;
  bit         uart_auto;
  int         busy_max;
  int         uart_busy;
  bit         uart_pend;

  uart_tx_arbiter #(
    .DEPTH        (DEPTH),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .req0Data    (req0Data),
    .req0Stb     (req0Stb),
    .req0Rdy     (req0Rdy),
    .req1Data    (req1Data),
    .req1Stb     (req1Stb),
    .req1Rdy     (req1Rdy),
    .txData      (txData),
    .txStb       (txStb),
    .txRdy       (txRdy),
    .grant       (grant),
    .ovf         (ovf),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    got_q.delete();
    stb_cyc_q.delete();
    m_ovf        = 2'b00;
    m_last_grant = 1'b1;
    last_stb_cyc = -100;
    prev_stb     = 1'b0;
    uart_busy    = 0;
    uart_pend    = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    req0Stb = 1'b0;
    req1Stb = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  // driver: one clock, then scoreboard update and UART response
  task automatic step();
    int         n0;
    int         n1;
    bit         pre_rdy;
    bit         s0;
    bit         s1;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         stb_seen;
    bit         exp_port;
    n0      = exp_q0.size();
    n1      = exp_q1.size();
    pre_rdy = txRdy;
    s0      = req0Stb;
    s1      = req1Stb;
    d0      = req0Data;
    d1      = req1Data;
    @(posedge CLK);
    #1;
    cyc++;
    if (s0) begin
      if (n0 < DEPTH) exp_q0.push_back(d0);
      else m_ovf[0] = 1'b1;
    end
    if (s1) begin
      if (n1 < DEPTH) exp_q1.push_back(d1);
      else m_ovf[1] = 1'b1;
    end
    stb_seen = (txStb === 1'b1);
    if (stb_seen) begin
      check("stb_needs_txrdy", 32'(pre_rdy), 32'd1);
      check("stb_spacing_ok", 32'((cyc - last_stb_cyc) >= 4), 32'd1);
`ifdef UART_ARB_LINELOCK_EN
      exp_port = grant;
`else
      exp_port = (n0 > 0 && n1 > 0) ? ~m_last_grant : (n1 > 0);
      check("grant", 32'(grant), 32'(exp_port));
`endif
      check("pop_src_nonempty", 32'(exp_port ? (n1 > 0) : (n0 > 0)), 32'd1);
      if (!exp_port && n0 > 0) check("txData_p0", 32'(txData), 32'(exp_q0.pop_front()));
      if (exp_port && n1 > 0) check("txData_p1", 32'(txData), 32'(exp_q1.pop_front()));
      m_last_grant = exp_port;
      got_q.push_back(txData);
      stb_cyc_q.push_back(cyc);
      last_stb_cyc = cyc;
    end
    check("stb_width", 32'(stb_seen && prev_stb), 32'd0);
    prev_stb = stb_seen;
    check("req0Rdy", 32'(req0Rdy), 32'(exp_q0.size() < DEPTH));
    check("req1Rdy", 32'(req1Rdy), 32'(exp_q1.size() < DEPTH));
    check("ovf", 32'(ovf), 32'(m_ovf));
    if (uart_auto) begin
      if (uart_pend) begin
        uart_pend = 1'b0;
        if (busy_max > 0) begin
          txRdy     = 1'b0;
          uart_busy = $urandom_range(busy_max, 1);
        end
      end else if (uart_busy > 0) begin
        uart_busy--;
        if (uart_busy == 0) txRdy = 1'b1;
      end
      if (stb_seen) uart_pend = 1'b1;
    end
    req0Stb = 1'b0;
    req1Stb = 1'b0;
  endtask

  initial begin
    int               k;
    logic [7:0]       order[6];
    RESET_N   = 1'b0;
    req0Data  = 8'h00;
    req1Data  = 8'h00;
    req0Stb   = 1'b0;
    req1Stb   = 1'b0;
    txRdy     = 1'b1;
    uart_auto = 1'b0;
    busy_max  = 0;
    cyc       = 0;
    model_reset();

    // reset values
    do_reset();
    check("rst_txData", 32'(txData), 32'h00);
    check("rst_txStb", 32'(txStb), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_req0Rdy", 32'(req0Rdy), 32'd1);
    check("rst_req1Rdy", 32'(req1Rdy), 32'd1);

    // first-byte latency
    txRdy    = 1'b1;
    req0Data = 8'h41;
    req0Stb  = 1'b1;
    step();
    check("lat_no_stb_yet", 32'(txStb), 32'd0);
    step();
    check("lat_stb", 32'(txStb), 32'd1);
    check("lat_data", 32'(txData), 32'h41);
    check("lat_grant", 32'(grant), 32'd0);
    step();
    check("lat_stb_one_cycle", 32'(txStb), 32'd0);

`ifndef UART_ARB_LINELOCK_EN
    // round-robin over a preloaded backlog
    do_reset();
    txRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req0Data = 8'h30 + 8'(i);
      req0Stb  = 1'b1;
      req1Data = 8'h61 + 8'(i);
      req1Stb  = 1'b1;
      step();
    end
    txRdy     = 1'b1;
    uart_auto = 1'b1;
    busy_max  = 3;
    k = 0;
    while (got_q.size() < 6 && k < 200) begin
      step();
      k++;
    end
    check("rr_count", 32'(got_q.size()), 32'd6);
    order = '{8'h30, 8'h61, 8'h31, 8'h62, 8'h32, 8'h63};
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) check("rr_order", 32'(got_q[i]), 32'(order[i]));
    end
`endif

    // overflow on port 1 with the UART stalled
    do_reset();
    uart_auto = 1'b0;
    txRdy     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req1Data = 8'hA0 + 8'(i);
      req1Stb  = 1'b1;
      step();
      if (i == 3) check("ovf_req1Rdy_full", 32'(req1Rdy), 32'd0);
    end
    check("ovf_flag", 32'(ovf), 32'h2);
    txRdy     = 1'b1;
    uart_auto = 1'b1;
    busy_max  = 2;
    repeat (60) step();
    check("ovf_drain_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() > 0) check("ovf_last_byte", 32'(got_q[got_q.size()-1]), 32'hA3);

    // random traffic: first with txRdy never dropping, then with a slow UART
    do_reset();
    uart_auto = 1'b1;
    txRdy     = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      busy_max = (phase == 0) ? 0 : 8;
      for (int i = 0; i < 300; i++) begin
        req0Stb  = ($urandom_range(2, 0) == 0);
        req0Data = 8'($urandom);
        req1Stb  = ($urandom_range(2, 0) == 0);
        req1Data = 8'($urandom);
        step();
      end
    end
    k = 0;
    while ((exp_q0.size() + exp_q1.size()) > 0 && k < 3000) begin
      step();
      k++;
    end
    check("rand_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    repeat (10) step();

`ifdef UART_ARB_LINELOCK_EN
    // line lock holds port 0 until LF
    do_reset();
    uart_auto = 1'b1;
    busy_max  = 2;
    txRdy     = 1'b1;
    req0Data  = "A";
    req0Stb   = 1'b1;
    step();
    req0Data = "B";
    req0Stb  = 1'b1;
    req1Data = "x";
    req1Stb  = 1'b1;
    step();
    req0Data = 8'h0A;
    req0Stb  = 1'b1;
    step();
    k = 0;
    while (got_q.size() < 4 && k < 200) begin
      step();
      k++;
    end
    check("lock_count", 32'(got_q.size()), 32'd4);
    order = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check("lock_order", 32'(got_q[i]), 32'(order[i]));
    end

    // lock released by timeout when port 0 stalls
    do_reset();
    txRdy    = 1'b1;
    req0Data = "A";
    req0Stb  = 1'b1;
    step();
    req1Data = "x";
    req1Stb  = 1'b1;
    step();
    k = 0;
    while (got_q.size() < 2 && k < 200) begin
      step();
      k++;
    end
    check("tmo_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("tmo_byte", 32'(got_q[1]), 32'h78);
      check("tmo_gap_min", 32'((stb_cyc_q[1] - stb_cyc_q[0]) >= LOCK_TIMEOUT), 32'd1);
      check("tmo_gap_max", 32'((stb_cyc_q[1] - stb_cyc_q[0]) <= LOCK_TIMEOUT + 8), 32'd1);
    end
`endif

    // reset pulled mid-byte with bytes still queued
    do_reset();
    uart_auto = 1'b0;
    txRdy     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req0Data = 8'h50 + 8'(i);
      req0Stb  = 1'b1;
      step();
    end
    txRdy = 1'b1;
    k = 0;
    while (txStb !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    check("mid_stb_seen", 32'(txStb), 32'd1);
    txRdy = 1'b0;
    step();
    #2;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_txStb", 32'(txStb), 32'd0);
    check("mid_rst_req0Rdy", 32'(req0Rdy), 32'd1);
    check("mid_rst_txData", 32'(txData), 32'h00);
    check("mid_rst_grant", 32'(grant), 32'd0);
    do_reset();
    txRdy     = 1'b1;
    uart_auto = 1'b1;
    busy_max  = 2;
    repeat (20) step();
    check("mid_no_strobes_after", 32'(got_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
